// File: rtl/i2c_arb_pkg.sv
// Shared encodings and bus widths for the I2C master arbiter.
// Pure definitions: no latency, no flow control.
package i2c_arb_pkg;
   localparam int I2C_ID_W   = 7;
   localparam int I2C_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_STOP   = 2'd2,
      ST_GAP    = 2'd3
   } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest requesting index at or above i_ptr, then wraps to below it.
// Combinational, zero latency; no grant when nothing requests.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [PTR_W-1:0]   o_idx
);
   logic w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      // Pass 0 scans indices >= ptr, pass 1 scans the wrapped part below ptr.
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] &&
                ((p == 0) ? (PTR_W'(i) >= i_ptr) : (PTR_W'(i) < i_ptr))) begin
               o_grant[i] = 1'b1;
               o_idx      = PTR_W'(i);
               w_found    = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Grants one i2c_wrapper master to NUM_REQ sequencers per whole transaction, round-robin, with watchdog and bus-free gap.
// Grant 1 cycle after request, o_m_* 1 cycle after owner inputs; ack/last routed back combinationally; losers wait.
module i2c_master_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int GAP_CYCLES     = 250,
   parameter int TIMEOUT_CYCLES = 250000
) (
   input  logic                           i_sysclk,
   input  logic                           i_arst,
   input  logic [NUM_REQ-1:0]             i_req_en,
   input  logic [NUM_REQ-1:0]             i_req_wr,
   input  logic [NUM_REQ-1:0]             i_req_last,
   input  logic [I2C_ID_W*NUM_REQ-1:0]    i_req_addr,
   input  logic [I2C_DATA_W*NUM_REQ-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]             o_req_ack,
   output logic [NUM_REQ-1:0]             o_req_last,
   output logic [I2C_DATA_W-1:0]          o_req_data,
   output logic [NUM_REQ-1:0]             o_grant,
   output logic [NUM_REQ-1:0]             o_timeout,
   output logic                           o_m_en,
   output logic                           o_m_wr,
   output logic                           o_m_last,
   output logic [I2C_ID_W-1:0]            o_m_addr,
   output logic [I2C_DATA_W-1:0]          o_m_data,
   input  logic                           i_m_ack,
   input  logic                           i_m_last,
   input  logic [I2C_DATA_W-1:0]          i_m_data
);
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   arb_state_t              r_state;
   logic [NUM_REQ-1:0]      r_grant;
   logic [PTR_W-1:0]        r_owner;
   logic [PTR_W-1:0]        r_rr_ptr;
   logic [NUM_REQ-1:0]      r_timeout;
   logic [WDOG_W-1:0]       r_wdog;
   logic [GAP_W-1:0]        r_gap;
   logic                    r_m_en;
   logic                    r_m_wr;
   logic                    r_m_last;
   logic [I2C_ID_W-1:0]     r_m_addr;
   logic [I2C_DATA_W-1:0]   r_m_data;

   logic [NUM_REQ-1:0]      w_arb_grant;
   logic [PTR_W-1:0]        w_arb_idx;
   logic [PTR_W-1:0]        w_next_ptr;
   logic                    w_own_en;
   logic                    w_own_wr;
   logic                    w_own_last;
   logic [I2C_ID_W-1:0]     w_own_addr;
   logic [I2C_DATA_W-1:0]   w_own_data;
   logic                    w_kick;
   logic                    w_busy;
   logic                    w_expire;
   logic                    w_release;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .i_req   (i_req_en),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx)
   );

   always_comb begin
      w_own_en   = 1'b0;
      w_own_wr   = 1'b0;
      w_own_last = 1'b0;
      w_own_addr = '0;
      w_own_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_owner == PTR_W'(i)) begin
            w_own_en   = i_req_en[i];
            w_own_wr   = i_req_wr[i];
            w_own_last = i_req_last[i];
            w_own_addr = i_req_addr[i*I2C_ID_W +: I2C_ID_W];
            w_own_data = i_req_data[i*I2C_DATA_W +: I2C_DATA_W];
         end
      end
   end

   assign w_next_ptr = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
   assign w_kick     = i_m_ack | i_m_last;
   assign w_busy     = (r_state == ST_ACTIVE) || (r_state == ST_STOP);
   // Master progress in the expiring cycle rescues the transaction.
   assign w_expire   = w_busy && !w_kick && (r_wdog >= WDOG_W'(TIMEOUT_CYCLES - 1));
   assign w_release  = (r_state == ST_STOP) && i_m_last;

   assign o_req_ack  = r_grant & {NUM_REQ{i_m_ack}};
   assign o_req_last = (r_state == ST_STOP) ? (r_grant & {NUM_REQ{i_m_last}}) : '0;
   assign o_req_data = (|r_grant) ? i_m_data : '0;
   assign o_grant    = r_grant;
   assign o_timeout  = r_timeout;
   assign o_m_en     = r_m_en;
   assign o_m_wr     = r_m_wr;
   assign o_m_last   = r_m_last;
   assign o_m_addr   = r_m_addr;
   assign o_m_data   = r_m_data;

   always_ff @(posedge i_sysclk or posedge i_arst) begin
      if (i_arst) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_rr_ptr  <= '0;
         r_timeout <= '0;
         r_wdog    <= '0;
         r_gap     <= '0;
         r_m_en    <= 1'b0;
         r_m_wr    <= 1'b0;
         r_m_last  <= 1'b0;
         r_m_addr  <= '0;
         r_m_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_m_en   <= 1'b0;
               r_m_wr   <= 1'b0;
               r_m_last <= 1'b0;
               r_m_addr <= '0;
               r_m_data <= '0;
               if (|i_req_en) begin
                  r_grant <= w_arb_grant;
                  r_owner <= w_arb_idx;
                  r_wdog  <= '0;
                  r_state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // en=0 with last=0 is a pause: owner keeps the grant, master sees en=0.
               r_m_en   <= w_own_en;
               r_m_wr   <= w_own_wr;
               r_m_last <= w_own_last;
               r_m_addr <= w_own_addr;
               r_m_data <= w_own_data;
               if (w_kick)
                  r_wdog <= '0;
               else if (!w_expire)
                  r_wdog <= r_wdog + WDOG_W'(1);
               if (!w_own_en && w_own_last)
                  r_state <= ST_STOP;
            end
            ST_STOP: begin
               r_m_en   <= 1'b0;
               r_m_last <= 1'b1;
               if (w_kick)
                  r_wdog <= '0;
               else if (!w_expire)
                  r_wdog <= r_wdog + WDOG_W'(1);
            end
            default: begin
               r_m_en   <= 1'b0;
               r_m_wr   <= 1'b0;
               r_m_last <= 1'b0;
               r_m_addr <= '0;
               r_m_data <= '0;
               if (r_gap >= GAP_W'(GAP_CYCLES - 1))
                  r_state <= ST_IDLE;
               else
                  r_gap <= r_gap + GAP_W'(1);
            end
         endcase

         // End of ownership overrides the per-state updates above.
         if (w_release || w_expire) begin
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_gap    <= '0;
            r_state  <= ST_GAP;
            r_m_en   <= 1'b0;
            r_m_wr   <= 1'b0;
            r_m_addr <= '0;
            r_m_data <= '0;
            r_m_last <= w_expire;
            if (w_expire)
               r_timeout <= r_timeout | r_grant;
         end
      end
   end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: two requesters, short watchdog, full-length gap.
`timescale 1ns/1ps
module tb_i2c_master_arbiter;
   localparam int NR   = 2;
   localparam int GAP  = 250;
   localparam int TMO  = 100;

   logic          i_sysclk = 1'b0;
   logic          i_arst   = 1'b1;
   logic [NR-1:0] i_req_en   = '0;
   logic [NR-1:0] i_req_wr   = '0;
   logic [NR-1:0] i_req_last = '0;
   logic [7*NR-1:0] i_req_addr = '0;
   logic [8*NR-1:0] i_req_data = '0;
   logic [NR-1:0] o_req_ack, o_req_last, o_grant, o_timeout;
   logic [7:0]    o_req_data;
   logic          o_m_en, o_m_wr, o_m_last;
   logic [6:0]    o_m_addr;
   logic [7:0]    o_m_data;
   logic          i_m_ack  = 1'b0;
   logic          i_m_last = 1'b0;
   logic [7:0]    i_m_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   i2c_master_arbiter #(
      .NUM_REQ        (NR),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_sysclk   (i_sysclk),
      .i_arst     (i_arst),
      .i_req_en   (i_req_en),
      .i_req_wr   (i_req_wr),
      .i_req_last (i_req_last),
      .i_req_addr (i_req_addr),
      .i_req_data (i_req_data),
      .o_req_ack  (o_req_ack),
      .o_req_last (o_req_last),
      .o_req_data (o_req_data),
      .o_grant    (o_grant),
      .o_timeout  (o_timeout),
      .o_m_en     (o_m_en),
      .o_m_wr     (o_m_wr),
      .o_m_last   (o_m_last),
      .o_m_addr   (o_m_addr),
      .o_m_data   (o_m_data),
      .i_m_ack    (i_m_ack),
      .i_m_last   (i_m_last),
      .i_m_data   (i_m_data)
   );

   always #5 i_sysclk = ~i_sysclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge i_sysclk);
   endtask

   // Cycles until any grant appears, bounded.
   task automatic wait_grant(output int n);
      n = 0;
      while (o_grant == '0 && n < 2000) begin
         tick();
         n++;
      end
   endtask

   int         n;
   int         bad;
   logic [7:0] byte_v;

   initial begin
      // Reset values
      repeat (3) tick();
      check("rst_grant", o_grant, 0);
      check("rst_m_en", o_m_en, 0);
      check("rst_m_last", o_m_last, 0);
      check("rst_m_addr", o_m_addr, 0);
      check("rst_timeout", o_timeout, 0);
      check("rst_req_ack", o_req_ack, 0);
      check("rst_req_data", o_req_data, 0);
      i_arst = 1'b0;
      tick();

      // Requester 0 alone: write to ID 0x10, three bytes
      i_req_en[0] = 1'b1;
      i_req_wr[0] = 1'b1;
      i_req_addr[6:0] = 7'h10;
      byte_v = 8'hA1;
      i_req_data[7:0] = byte_v;
      tick();
      check("b_grant", o_grant, 2'b01);
      check("b_m_en_early", o_m_en, 0);
      tick();
      check("b_m_en", o_m_en, 1);
      check("b_m_addr", o_m_addr, 7'h10);
      check("b_m_wr", o_m_wr, 1);
      for (int b = 0; b < 3; b++) begin
         check("b_m_data", o_m_data, byte_v);
         i_m_ack = 1'b1;
         i_m_data = 8'h5A + 8'(b);
         #1;
         check("b_req_ack", o_req_ack, 2'b01);
         check("b_req_data", o_req_data, 8'h5A + 8'(b));
         tick();
         i_m_ack = 1'b0;
         byte_v = byte_v + 8'h11;
         i_req_data[7:0] = byte_v;
         tick();
      end
      i_req_en[0] = 1'b0;
      i_req_last[0] = 1'b1;
      tick();
      check("b_stop_m_last", o_m_last, 1);
      check("b_stop_m_en", o_m_en, 0);
      check("b_stop_req_last_idle", o_req_last, 0);
      repeat (2) tick();
      check("b_stop_hold", {o_grant, o_m_last}, 3'b011);
      i_m_last = 1'b1;
      #1;
      check("b_req_last", o_req_last, 2'b01);
      tick();
      i_m_last = 1'b0;
      i_req_last[0] = 1'b0;
      #1;
      check("b_req_last_pulse", o_req_last, 0);
      check("b_gap_grant", o_grant, 0);
      check("b_gap_m_last", o_m_last, 0);
      i_m_ack = 1'b1;
      #1;
      check("b_gap_ack_ignored", o_req_ack, 0);
      i_m_ack = 1'b0;

      // Same requester again; master never acks -> watchdog
      i_req_en[0] = 1'b1;
      wait_grant(n);
      // GAP cycles in gap plus one IDLE cycle to register the grant
      check("c_gap_len", n, GAP + 1);
      check("c_grant", o_grant, 2'b01);
      i_req_en[1] = 1'b1;
      i_req_addr[13:7] = 7'h22;
      n = 0;
      while (!o_m_last && n < 1000) begin
         tick();
         n++;
      end
      check("c_tmo_cycles", n, TMO);
      check("c_tmo_m_en", o_m_en, 0);
      check("c_tmo_flag", o_timeout, 2'b01);
      check("c_tmo_grant", o_grant, 0);
      tick();
      check("c_tmo_m_last_pulse", o_m_last, 0);
      i_req_en[0] = 1'b0;
      wait_grant(n);
      // counted from the cycle after the forced-stop pulse
      check("c_gap_len2", n, GAP);
      check("c_grant1", o_grant, 2'b10);
      check("c_tmo_sticky", o_timeout, 2'b01);
      tick();
      check("c_m_addr1", o_m_addr, 7'h22);
      i_m_ack = 1'b1;
      #1;
      check("c_req_ack1", o_req_ack, 2'b10);
      tick();
      i_m_ack = 1'b0;
      i_req_en[1] = 1'b0;
      i_req_last[1] = 1'b1;
      tick();
      check("c_stop1", o_m_last, 1);
      i_m_last = 1'b1;
      #1;
      check("c_req_last1", o_req_last, 2'b10);
      tick();
      i_m_last = 1'b0;
      i_req_last[1] = 1'b0;

      // Reset in the middle of an active transaction
      i_req_en[0] = 1'b1;
      wait_grant(n);
      check("e_grant", o_grant, 2'b01);
      tick();
      check("e_active", o_m_en, 1);
      i_arst = 1'b1;
      #1;
      check("e_rst_grant", o_grant, 0);
      check("e_rst_m_en", o_m_en, 0);
      check("e_rst_timeout", o_timeout, 0);
      check("e_rst_m_addr", o_m_addr, 0);
      i_req_en = '0;
      repeat (2) tick();
      i_arst = 1'b0;
      tick();

      // Both request in the same cycle; owner 0 pauses for 50 cycles
      i_req_en = 2'b11;
      tick();
      check("f_grant0", o_grant, 2'b01);
      tick();
      check("f_m_addr0", o_m_addr, 7'h10);
      i_m_ack = 1'b1;
      #1;
      check("f_ack0_only", o_req_ack, 2'b01);
      tick();
      i_m_ack = 1'b0;
      i_req_en[0] = 1'b0;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (o_grant !== 2'b01 || o_m_en !== 1'b0) bad++;
      end
      check("f_pause_held", bad, 0);
      i_req_en[0] = 1'b1;
      tick();
      check("f_resume", {o_grant, o_m_en}, 3'b011);
      i_req_en[0] = 1'b0;
      i_req_last[0] = 1'b1;
      tick();
      i_m_last = 1'b1;
      #1;
      check("f_req_last0", o_req_last, 2'b01);
      tick();
      i_m_last = 1'b0;
      i_req_last[0] = 1'b0;
      n = 0;
      bad = 0;
      while (o_grant !== 2'b10 && n < 2000) begin
         i_m_ack = 1'b1;
         #1;
         if (o_req_ack !== 2'b00 || o_m_addr === 7'h22) bad++;
         i_m_ack = 1'b0;
         tick();
         n++;
      end
      check("f_no_early_ack1", bad, 0);
      check("f_gap_len", n, GAP + 1);
      tick();
      check("f_m_addr1", o_m_addr, 7'h22);
      i_req_en[1] = 1'b0;
      i_req_last[1] = 1'b1;
      tick();
      i_m_last = 1'b1;
      #1;
      check("f_req_last1", o_req_last, 2'b10);
      tick();
      i_m_last = 1'b0;
      i_req_last[1] = 1'b0;
      i_req_en = 2'b11;
      wait_grant(n);
      check("f_next_round0", o_grant, 2'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
